// File: rtl/if_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// if_fetch_unit : PC owner, req/ack I-memory fetch, DEPTH-entry prefetch queue
// Option IFQ_BYPASS_EN: ack on an empty queue feeds IF/ID in the same cycle.
// Revision 1.0
// ============================================================================
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic        Valid,
    output logic [31:0] Instruction,
    output logic [31:0] PCAddResult
);

    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_KILL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      entry_q [DEPTH];
    logic [63:0]      entry_d [DEPTH];

    logic        ack_take;
    logic        head_valid;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        credit;
    logic [63:0] head_entry;

    // Queue bookkeeping; entries hold {fetch address + 4, instruction}.
    always_comb begin
        ack_take   = (state_q == ST_WAIT) && IMemAck && !Redirect;
        head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
        bypass     = ack_take && !head_valid && !Stall;
`else
        bypass     = 1'b0;
`endif
        push       = ack_take && !bypass;
        pop        = head_valid && !Stall && !Redirect;

        entry_d = entry_q;
        if (push) begin
            entry_d[wr_ptr_q] = {addr_q + 32'd4, IMemData};
        end

        if (Redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (Redirect) begin
            fetch_pc_d = RedirectPC;
        end else if (ack_take) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // Only one request is ever in flight, so a free slot now covers its reply.
        credit = (count_d < DEPTH_CNT);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_FETCH: begin
                addr_d = fetch_pc_d;
                if (credit) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Redirect) begin
                    if (IMemAck) begin
                        state_d = ST_FETCH;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = ST_KILL;
                    end
                end else if (IMemAck) begin
                    addr_d  = fetch_pc_d;
                    state_d = credit ? ST_WAIT : ST_FETCH;
                end
            end
            ST_KILL: begin
                // Old address stays on the bus until the doomed reply arrives.
                if (IMemAck) begin
                    state_d = ST_FETCH;
                    addr_d  = fetch_pc_d;
                end
            end
            default: begin
                state_d = ST_FETCH;
                addr_d  = fetch_pc_d;
            end
        endcase
        req_d = (state_d != ST_FETCH);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            entry_q    <= entry_d;
        end
    end

    always_comb begin
        head_entry  = entry_q[rd_ptr_q];
        IMemReq     = req_q;
        IMemAddr    = addr_q;
        Valid       = head_valid || bypass;
        Instruction = head_entry[31:0];
        PCAddResult = head_entry[63:32];
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            Instruction = IMemData;
            PCAddResult = addr_q + 32'd4;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_if_fetch_unit : scoreboard bench for if_fetch_unit (honours IFQ_BYPASS_EN)
// Revision 1.0
// ============================================================================
module tb_if_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam logic        BYP      = 1'b1;
`else
    localparam logic        BYP      = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic        Valid;
    logic [31:0] Instruction;
    logic [31:0] PCAddResult;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk(Clk), .Reset(Reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .IMemData(IMemData), .Valid(Valid), .Instruction(Instruction),
        .PCAddResult(PCAddResult)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    int          mem_lat = 0;
    int          lat_cnt = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_kill = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        new_req = 1'b0;
    logic        stall_cmd = 1'b0, redir_cmd = 1'b0;
    logic [31:0] redir_pc = '0;
    int          deliveries = 0;
    logic [31:0] last_pc4 = '0;
    logic        saw_wrap = 1'b0;
    logic        s_req, s_valid;
    logic [31:0] s_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req",   32'(IMemReq), 32'd0);
        check("rst_addr",  IMemAddr, RESET_PC);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_pc4",   PCAddResult, 32'd0);
    endtask

    task automatic clear_model();
        sb.delete();
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_kill = 1'b0;
        lat_cnt   = 0;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; IMemAck = 1'b0;
        stall_cmd = 1'b0; redir_cmd = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        clear_model();
    endtask

    // One clock: memory model drives ack/data, expected words are queued,
    // then outputs are sampled and any delivered word is scoreboarded.
    task automatic cycle();
        logic ack;
        logic [63:0] e;
        @(negedge Clk);
        Stall = stall_cmd; Redirect = redir_cmd; RedirectPC = redir_pc;
        ack = 1'b0; new_req = 1'b0;
        if (IMemReq) begin
            if (prev_req && !prev_ack) begin
                check("addr_stable", IMemAddr, prev_addr);
            end else begin
                new_req = 1'b1;
                lat_cnt = mem_lat;
            end
            if (lat_cnt == 0) ack = 1'b1;
            else lat_cnt--;
        end
        IMemAck  = ack;
        IMemData = ack ? IMemAddr : 32'hDEAD_BEEF;
        if (ack) begin
            if (!redir_cmd && !prev_kill) sb.push_back({IMemAddr + 32'd4, IMemAddr});
            prev_kill = 1'b0;
        end else if (redir_cmd && IMemReq) begin
            prev_kill = 1'b1;
        end
        prev_req = IMemReq; prev_ack = ack; prev_addr = IMemAddr;
        #1;
        s_req = IMemReq; s_addr = IMemAddr; s_valid = Valid;
        if (Valid && !Stall && !Redirect) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(Valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("instr", Instruction, e[31:0]);
                check("pc4", PCAddResult, e[63:32]);
                deliveries++;
                last_pc4 = PCAddResult;
                if (PCAddResult == 32'd0) saw_wrap = 1'b1;
            end
        end
        if (Redirect) sb.delete();
        redir_cmd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        // Reset values
        #12;
        check_reset_vals();
        @(negedge Clk);
        Reset = 1'b1;
        clear_model();

        // Streaming with zero-latency memory
        mem_lat = 0;
        cycle();
        check("t1_req", 32'(s_req), 32'd1);
        check("t1_addr", s_addr, RESET_PC);
        check("t1_valid_c1", 32'(s_valid), 32'(BYP));
        cycle();
        check("t1_valid_c2", 32'(s_valid), 32'd1);
        repeat (10) cycle();
        check("t1_throughput", 32'(deliveries), BYP ? 32'd12 : 32'd11);

        // Stall fills the queue, then drains in order
        apply_reset();
        deliveries = 0;
        stall_cmd = 1'b1;
        repeat (10) cycle();
        check("t2_queued", 32'(sb.size()), 32'(DEPTH));
        check("t2_req_low", 32'(s_req), 32'd0);
        check("t2_valid", 32'(s_valid), 32'd1);
        stall_cmd = 1'b0;
        cycle();
        cycle();
        check("t2_resume_req", 32'(s_req), 32'd1);
        check("t2_resume_addr", s_addr, 32'd16);
        repeat (4) cycle();
        check("t2_drain", 32'(deliveries), 32'd6);

        // Redirect while a slow request is outstanding
        apply_reset();
        mem_lat = 3;
        repeat (10) cycle();
        k = 0;
        do begin cycle(); k++; end while (!new_req && k < 20);
        check("t3_wait_req", 32'(new_req), 32'd1);
        redir_cmd = 1'b1; redir_pc = 32'h100;
        cycle();
        d0 = deliveries;
        k = 0;
        do begin cycle(); k++; end while (!new_req && k < 20);
        check("t3_new_req", 32'(new_req), 32'd1);
        check("t3_new_addr", s_addr, 32'h100);
        k = 0;
        while (deliveries == d0 && k < 20) begin cycle(); k++; end
        check("t3_delivered", 32'(deliveries > d0), 32'd1);
        check("t3_first_pc4", last_pc4, 32'h104);

        // Redirect and ack in the same cycle
        mem_lat = 0;
        repeat (6) cycle();
        redir_cmd = 1'b1; redir_pc = 32'h200;
        cycle();
        check("t4_ack_same", 32'(prev_ack), 32'd1);
        cycle();
        check("t4_valid", 32'(s_valid), 32'd0);
        check("t4_req", 32'(s_req), 32'd0);
        check("t4_addr", s_addr, 32'h200);
        cycle();
        check("t4_next_req", 32'(s_req), 32'd1);
        check("t4_next_addr", s_addr, 32'h200);

        // PC wraps at the top of the address space
        saw_wrap = 1'b0;
        redir_cmd = 1'b1; redir_pc = 32'hFFFF_FFF8;
        cycle();
        repeat (8) cycle();
        check("t5_wrap", 32'(saw_wrap), 32'd1);

        // Asynchronous reset mid-WAIT with two entries queued
        apply_reset();
        stall_cmd = 1'b1;
        mem_lat = 2;
        k = 0;
        do begin cycle(); k++; end while (!(sb.size() == 2 && s_req && !prev_ack) && k < 30);
        check("t6_setup", 32'(sb.size()), 32'd2);
        #2;
        Reset = 1'b0;
        IMemAck = 1'b0;
        #1;
        check_reset_vals();
        @(negedge Clk);
        Reset = 1'b1;
        clear_model();
        stall_cmd = 1'b0;
        mem_lat = 0;
        cycle();
        check("t6_restart_req", 32'(s_req), 32'd1);
        check("t6_restart_addr", s_addr, RESET_PC);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
